// File: rtl/instr_reg.sv
// Four-phase handshake instruction register: captures one 16-bit word per
// request/acknowledge cycle, with PH1 and ack_next brought in through 2-flop synchronizers.
module instr_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data,
    input  logic [1:0]  PH1,
    output logic [15:0] instr,
    input  logic        ack_next,
    output logic        ack_befo
);

    localparam logic [1:0] PH_NULL = 2'b00;
    localparam logic [1:0] PH_REQ  = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        CONSUMED = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ph1_meta_q, ph1_s_q;
    logic        ack_meta_q, ack_s_q;
    logic [15:0] instr_q, instr_d;
    logic        ack_befo_q, ack_befo_d;

    // Control inputs arrive from another timing domain; data is bundled and
    // only sampled once the synchronized request says it is stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph1_meta_q <= 2'b00;
            ph1_s_q    <= 2'b00;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ph1_meta_q <= PH1;
            ph1_s_q    <= ph1_meta_q;
            ack_meta_q <= ack_next;
            ack_s_q    <= ack_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            instr_q    <= 16'h0000;
            ack_befo_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            ack_befo_q <= ack_befo_d;
        end
    end

    // Illegal PH1 codes fall through every test below: neither a request nor a null.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        ack_befo_d = ack_befo_q;
        case (state_q)
            IDLE: begin
                if (ph1_s_q == PH_REQ && !ack_s_q) begin
                    instr_d    = data;
                    ack_befo_d = 1'b1;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (ack_s_q) begin
                    if (ph1_s_q == PH_NULL) begin
                        state_d    = DRAIN;
                        ack_befo_d = 1'b0;
                    end else begin
                        state_d = CONSUMED;
                    end
                end
            end
            CONSUMED: begin
                if (ph1_s_q == PH_NULL) begin
                    state_d    = DRAIN;
                    ack_befo_d = 1'b0;
                end
            end
            DRAIN: begin
                if (!ack_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                ack_befo_d = 1'b0;
            end
        endcase
    end

    assign instr    = instr_q;
    assign ack_befo = ack_befo_q;

endmodule

// File: tb/tb_instr_reg.sv
// Randomized and directed bench for instr_reg: a protocol-level reference model
// feeds a scoreboard queue that a negedge monitor drains against the DUT outputs.
module tb_instr_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [1:0]  PH1;
    logic [15:0] instr;
    logic        ack_next;
    logic        ack_befo;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic [15:0] instr;
        logic        ack;
    } exp_t;

    exp_t sb[$];

    instr_reg dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .PH1      (PH1),
        .instr    (instr),
        .ack_next (ack_next),
        .ack_befo (ack_befo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            passes++;
    endtask

    // Reference model: the handshake expressed as protocol facts.
    logic [1:0]  m_ph_seen [2];
    logic        m_ack_seen[2];
    logic [15:0] m_word;
    bit          m_holding;     // we are acknowledging a captured word
    bit          m_taken;       // next stage has acknowledged that word
    bit          m_draining;    // waiting for next stage to release its ack

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph_seen  = '{2'b00, 2'b00};
            m_ack_seen = '{1'b0, 1'b0};
            m_word     = 16'h0000;
            m_holding  = 0;
            m_taken    = 0;
            m_draining = 0;
            sb.delete();
            if (clk) sb.push_back('{16'h0000, 1'b0});
        end else begin
            logic [1:0] ph_now;
            logic       ack_now;
            ph_now  = m_ph_seen[1];
            ack_now = m_ack_seen[1];
            if (m_draining) begin
                if (!ack_now) m_draining = 0;
            end else if (m_holding) begin
                if (ack_now) m_taken = 1;
                if (m_taken && ph_now == 2'b00) begin
                    m_holding  = 0;
                    m_taken    = 0;
                    m_draining = 1;
                end
            end else if (ph_now == 2'b10 && !ack_now) begin
                m_word    = data;
                m_holding = 1;
            end
            m_ph_seen[1]  = m_ph_seen[0];
            m_ph_seen[0]  = PH1;
            m_ack_seen[1] = m_ack_seen[0];
            m_ack_seen[0] = ack_next;
            sb.push_back('{m_word, m_holding});
        end
    end

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_instr", instr, e.instr);
            chk("sb_ack_befo", {15'd0, ack_befo}, {15'd0, e.ack});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic handshake(input logic [15:0] word);
        data = word;
        PH1  = 2'b10;
        cyc(2);
        chk("hs_ack_before_3rd_edge", {15'd0, ack_befo}, 16'd0);
        cyc(1);
        chk("hs_capture_instr", instr, word);
        chk("hs_capture_ack", {15'd0, ack_befo}, 16'd1);
        ack_next = 1'b1;
        cyc(5);
        PH1  = 2'b00;
        data = 16'h0000;
        cyc(3);
        chk("hs_release_ack", {15'd0, ack_befo}, 16'd0);
        chk("hs_release_instr", instr, word);
        ack_next = 1'b0;
        cyc(4);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; data = 16'hFFFF; PH1 = 2'b10; ack_next = 1'b0;
        cyc(2);
        chk("reset_instr", instr, 16'h0000);
        chk("reset_ack", {15'd0, ack_befo}, 16'd0);
        cyc(2);
        PH1 = 2'b00; data = 16'h0000;
        cyc(1);
        rst = 1'b0;
        cyc(3);

        handshake(16'h95AA);

        // Null arrives before the acknowledge.
        data = 16'h1111; PH1 = 2'b10;
        cyc(4);
        PH1 = 2'b00;
        cyc(6);
        chk("early_null_ack_held", {15'd0, ack_befo}, 16'd1);
        ack_next = 1'b1;
        cyc(3);
        chk("early_null_release", {15'd0, ack_befo}, 16'd0);
        ack_next = 1'b0;
        cyc(4);

        // Request blocked while next stage still acknowledges.
        ack_next = 1'b1; data = 16'h2222; PH1 = 2'b10;
        cyc(6);
        chk("blocked_ack", {15'd0, ack_befo}, 16'd0);
        chk("blocked_instr", instr, 16'h1111);
        ack_next = 1'b0;
        cyc(2);
        chk("blocked_pre_capture", {15'd0, ack_befo}, 16'd0);
        cyc(1);
        chk("unblocked_capture_ack", {15'd0, ack_befo}, 16'd1);
        chk("unblocked_capture_instr", instr, 16'h2222);
        ack_next = 1'b1; cyc(4);
        PH1 = 2'b00; cyc(4);
        ack_next = 1'b0; cyc(4);

        // Illegal request codes in IDLE.
        data = 16'h1234; PH1 = 2'b11;
        cyc(5);
        chk("illegal11_instr", instr, 16'h2222);
        chk("illegal11_ack", {15'd0, ack_befo}, 16'd0);
        PH1 = 2'b01;
        cyc(5);
        chk("illegal01_instr", instr, 16'h2222);
        chk("illegal01_ack", {15'd0, ack_befo}, 16'd0);
        PH1 = 2'b00;
        cyc(3);

        // Reset while in CONSUMED.
        data = 16'hABCD; PH1 = 2'b10;
        cyc(4);
        ack_next = 1'b1;
        cyc(5);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset_instr", instr, 16'h0000);
        chk("midreset_ack", {15'd0, ack_befo}, 16'd0);
        PH1 = 2'b00; ack_next = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(3);
        handshake(16'h95AA);

        // Randomized traffic, including illegal codes and ack glitches.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) begin
                int r;
                r = $urandom_range(9);
                PH1 = (r < 5) ? 2'b10 : (r < 8) ? 2'b00 : (r == 8) ? 2'b01 : 2'b11;
            end
            if ($urandom_range(4) == 0) ack_next = ~ack_next;
            if ($urandom_range(2) == 0) data = 16'($urandom);
        end
        PH1 = 2'b00; ack_next = 1'b0;
        cyc(8);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/instr_reg.md
INSTR_REG -- requirements
Module: instr_reg

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 data  input  16  instruction word from the previous stage; bundled data, stable while PH1 = 2'b10.
REQ-005 PH1  input  2  request code from the previous stage: 2'b00 = null/spacer, 2'b10 = request; 2'b01 and 2'b11 = illegal.
REQ-006 instr  output  16  registered instruction word.
REQ-007 ack_next  input  1  acknowledge from the next stage.
REQ-008 ack_befo  output  1  acknowledge to the previous stage; registered.

Function
REQ-009 PH1 and ack_next SHALL each pass through a 2-flop synchronizer; the FSM SHALL use only the synchronized copies (PH1_s, ack_s).
REQ-010 data SHALL NOT be synchronized; it SHALL be sampled directly on the capture edge.
REQ-011 The FSM SHALL have four states: IDLE, HOLD, CONSUMED and DRAIN.
REQ-012 IDLE: ack_befo = 0. If PH1_s == 2'b10 and ack_s == 0, then instr <= data, ack_befo <= 1 and next state is HOLD; otherwise the state is unchanged.
REQ-013 HOLD: ack_befo = 1 and instr is frozen. Transitions:
- ack_s == 1 and PH1_s == 2'b00 -> DRAIN, with ack_befo <= 0.
- ack_s == 1 with any other PH1_s -> CONSUMED.
- otherwise the state is unchanged, even if PH1_s == 2'b00.
REQ-014 CONSUMED: ack_befo = 1. PH1_s == 2'b00 -> DRAIN, with ack_befo <= 0; otherwise the state is unchanged, regardless of ack_s.
REQ-015 DRAIN: ack_befo = 0. ack_s == 0 -> IDLE; otherwise the state is unchanged.
REQ-016 instr SHALL change only on a capture in IDLE; it SHALL retain its value through HOLD, CONSUMED, DRAIN and IDLE until the next capture.
REQ-017 Latency: a PH1 or ack_next change at the input SHALL be reflected in ack_befo (and in instr on capture) at the 3rd rising clk edge after the change (2 synchronizer edges + 1 FSM edge).
REQ-018 Illegal PH1_s codes (01, 11) SHALL be treated as "not request" in IDLE and as "not null" in HOLD and CONSUMED; they SHALL NOT corrupt instr.
REQ-019 PH1_s == 2'b10 while ack_s == 1 in IDLE SHALL NOT capture; the FSM SHALL wait for ack_s to fall.
REQ-020 Only one instruction SHALL be captured per four-phase cycle; re-capture SHALL require the sequence DRAIN -> IDLE.

Reset
REQ-021 While rst = 1, asynchronously: instr = 16'h0000, ack_befo = 0, state = IDLE, and all synchronizer flops = 0.
REQ-022 After rst deasserts, the first capture SHALL need a fresh PH1 = 2'b10 observed through the synchronizers.
REQ-023 An assertion of rst in any state (mid-handshake) SHALL immediately force the values in REQ-021.

Verification
REQ-024 Reset check: rst = 1 with data = 16'hFFFF and PH1 = 2'b10 -> instr = 16'h0000 and ack_befo = 0 throughout reset.
REQ-025 Full handshake:
- data = 16'h95AA, then PH1 = 2'b10 -> instr = 16'h95AA and ack_befo = 1 at the 3rd edge.
- ack_next = 1, then PH1 = 2'b00 and data = 16'h0000 -> ack_befo = 0 within 3 edges, and instr stays 16'h95AA.
- ack_next = 0 -> FSM returns to IDLE.
REQ-026 Early null: in HOLD, set PH1 = 2'b00 before ack_next -> ack_befo stays 1; then ack_next = 1 -> ack_befo = 0 within 3 edges.
REQ-027 Blocked capture: ack_next = 1 with PH1 = 2'b10 in IDLE -> no capture and ack_befo = 0; drop ack_next -> capture occurs 3 edges later.
REQ-028 Illegal code: PH1 = 2'b11 or 2'b01 in IDLE with data = 16'h1234 -> instr unchanged and ack_befo = 0.
REQ-029 Reset mid-handshake: assert rst while in CONSUMED -> instr = 16'h0000 and ack_befo = 0 immediately; after release the block behaves as in REQ-025.
